idct_serial: RTL and testbench

- 8-point inverse DCT. Takes one block of eight signed 19-bit DCT coefficients, the same format the forward DCT stage produces, and returns eight signed 8-bit reconstructed samples.
- Sits on the decompression path, after RLE decoding, and mirrors the forward DCT stage.
- Area is traded for latency: eight parallel MAC lanes iterate over the coefficient index k for 8 cycles, then round, saturate and hold the result behind a valid/ready handshake.

---
 rtl/idct_pkg.sv | 48 ++++
 rtl/idct_mac_lane.sv | 38 +++
 rtl/idct_serial.sv | 136 +++++++++++++
 tb/tb_idct_serial.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// ============================================================================
// Module   : idct_pkg
// Brief    : Shared widths, cosine ROM, FSM encoding and saturation helper
//            for the serial 8-point inverse DCT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package idct_pkg;

    localparam int COEF_W = 19;
    localparam int ROM_W  = 12;
    localparam int SHIFT  = 11;
    localparam int ACC_W  = COEF_W + ROM_W + 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic signed [ACC_W-1:0] c_round_bias = ACC_W'(1 << (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] c_sat_max    = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] c_sat_min    = -ACC_W'(128);

    // c_cos_rom[k][n] = round(2048 * a(k) * cos((2n+1)k*pi/16))
    localparam logic signed [ROM_W-1:0] c_cos_rom [8][8] = '{
        '{ 12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724 },
        '{ 12'sd1004,  12'sd851,   12'sd569,   12'sd200,  -12'sd200,  -12'sd569,  -12'sd851,  -12'sd1004 },
        '{ 12'sd946,   12'sd392,  -12'sd392,  -12'sd946,  -12'sd946,  -12'sd392,   12'sd392,   12'sd946 },
        '{ 12'sd851,  -12'sd200,  -12'sd1004, -12'sd569,   12'sd569,   12'sd1004,  12'sd200,  -12'sd851 },
        '{ 12'sd724,  -12'sd724,  -12'sd724,   12'sd724,   12'sd724,  -12'sd724,  -12'sd724,   12'sd724 },
        '{ 12'sd569,  -12'sd1004,  12'sd200,   12'sd851,  -12'sd851,  -12'sd200,   12'sd1004, -12'sd569 },
        '{ 12'sd392,  -12'sd946,   12'sd946,  -12'sd392,  -12'sd392,   12'sd946,  -12'sd946,   12'sd392 },
        '{ 12'sd200,  -12'sd569,   12'sd851,  -12'sd1004,  12'sd1004, -12'sd851,   12'sd569,  -12'sd200 }
    };

    function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] v);
        if (v > c_sat_max) begin
            return 8'sd127;
        end else if (v < c_sat_min) begin
            return -8'sd128;
        end
        return v[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/idct_mac_lane.sv
// ============================================================================
// Module   : idct_mac_lane
// Brief    : One signed multiply-accumulate lane of the serial inverse DCT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idct_mac_lane
    import idct_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_en,
    input  logic signed [COEF_W-1:0] i_coef,
    input  logic signed [ROM_W-1:0]  i_rom,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [COEF_W+ROM_W-1:0] w_prod;
    logic signed [ACC_W-1:0]        r_acc;

    assign w_prod = i_coef * i_rom;
    assign o_acc  = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

endmodule

`default_nettype wire

// File: rtl/idct_serial.sv
// ============================================================================
// Module   : idct_serial
// Brief    : Serial 8-point inverse DCT: eight MAC lanes iterate k over eight
//            cycles, then round, saturate and hold behind valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idct_serial
    import idct_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     cs,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_z0,
    input  logic signed [COEF_W-1:0] in_z1,
    input  logic signed [COEF_W-1:0] in_z2,
    input  logic signed [COEF_W-1:0] in_z3,
    input  logic signed [COEF_W-1:0] in_z4,
    input  logic signed [COEF_W-1:0] in_z5,
    input  logic signed [COEF_W-1:0] in_z6,
    input  logic signed [COEF_W-1:0] in_z7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [7:0]        out_x0,
    output logic signed [7:0]        out_x1,
    output logic signed [7:0]        out_x2,
    output logic signed [7:0]        out_x3,
    output logic signed [7:0]        out_x4,
    output logic signed [7:0]        out_x5,
    output logic signed [7:0]        out_x6,
    output logic signed [7:0]        out_x7
);

    logic [1:0]               r_state;
    logic [2:0]               r_k;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic signed [COEF_W-1:0] r_xreg  [8];
    logic signed [7:0]        r_out_x [8];
    logic signed [ACC_W-1:0]  w_acc   [8];
    logic signed [COEF_W-1:0] w_coef;
    logic                     w_accept;
    logic                     w_lane_en;

    assign w_accept  = en & cs & in_valid & r_in_ready;
    assign w_lane_en = en & (r_state == ST_ACCUM);
    assign w_coef    = r_xreg[r_k];

    // All lanes share the same coefficient X[k]; each picks its own ROM column.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            idct_mac_lane u_lane (
                .clk     (clk),
                .rst     (rst),
                .i_clear (w_accept),
                .i_en    (w_lane_en),
                .i_coef  (w_coef),
                .i_rom   (c_cos_rom[r_k][gi]),
                .o_acc   (w_acc[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k         <= 3'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            for (int n = 0; n < 8; n++) begin
                r_xreg[n]  <= '0;
                r_out_x[n] <= '0;
            end
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_xreg[0]  <= in_z0;
                        r_xreg[1]  <= in_z1;
                        r_xreg[2]  <= in_z2;
                        r_xreg[3]  <= in_z3;
                        r_xreg[4]  <= in_z4;
                        r_xreg[5]  <= in_z5;
                        r_xreg[6]  <= in_z6;
                        r_xreg[7]  <= in_z7;
                        r_k        <= 3'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    r_k <= r_k + 3'd1;
                    if (r_k == 3'd7) begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    // Half toward +inf: add bias, then arithmetic shift.
                    for (int n = 0; n < 8; n++) begin
                        r_out_x[n] <= sat8((w_acc[n] + c_round_bias) >>> SHIFT);
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_x0    = r_out_x[0];
    assign out_x1    = r_out_x[1];
    assign out_x2    = r_out_x[2];
    assign out_x3    = r_out_x[3];
    assign out_x4    = r_out_x[4];
    assign out_x5    = r_out_x[5];
    assign out_x6    = r_out_x[6];
    assign out_x7    = r_out_x[7];

endmodule

`default_nettype wire

// File: tb/tb_idct_serial.sv
// ============================================================================
// Module   : tb_idct_serial
// Brief    : Scoreboard bench for idct_serial against a real-arithmetic IDCT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idct_serial;

    localparam int SH = 11;

    logic              clk = 1'b0;
    logic              rst, en, cs, in_valid, out_ready;
    logic              in_ready, out_valid;
    logic signed [18:0] in_z  [8];
    logic signed [7:0]  out_x [8];
    logic [63:0]       outv;

    int                rom [8][8];
    logic [63:0]       expq [$];
    int                nchk = 0;
    int                nerr = 0;

    always #5 clk = ~clk;

    idct_serial dut (
        .clk(clk), .rst(rst), .en(en), .cs(cs),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_z0(in_z[0]), .in_z1(in_z[1]), .in_z2(in_z[2]), .in_z3(in_z[3]),
        .in_z4(in_z[4]), .in_z5(in_z[5]), .in_z6(in_z[6]), .in_z7(in_z[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x0(out_x[0]), .out_x1(out_x[1]), .out_x2(out_x[2]), .out_x3(out_x[3]),
        .out_x4(out_x[4]), .out_x5(out_x[5]), .out_x6(out_x[6]), .out_x7(out_x[7])
    );

    assign outv = {out_x[7], out_x[6], out_x[5], out_x[4],
                   out_x[3], out_x[2], out_x[1], out_x[0]};

    task automatic check(input string name, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: x[n] = sat8(floor((sum_k X[k]*C[k][n] + 2^(SH-1)) / 2^SH))
    function automatic logic [63:0] model(input int x[8]);
        longint     acc;
        longint     r;
        logic [63:0] o;
        o = '0;
        for (int n = 0; n < 8; n++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) begin
                acc += longint'(x[k]) * longint'(rom[k][n]);
            end
            r = (acc + (longint'(1) <<< (SH - 1))) >>> SH;
            if (r > 127)  r = 127;
            if (r < -128) r = -128;
            o[8*n +: 8] = r[7:0];
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x[8], output int waited);
        int t;
        for (int i = 0; i < 8; i++) in_z[i] = 19'(x[i]);
        cs       = 1'b1;
        in_valid = 1'b1;
        t        = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(en && in_ready && !rst) && t < 60);
        waited = t;
        if (!(en && in_ready && !rst)) begin
            nchk++;
            nerr++;
            $display("FAIL accept_timeout: got in_ready=%0b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        expq.push_back(model(x));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            nchk++;
            nerr++;
            $display("FAIL valid_timeout: got out_valid=%0b expected 1", out_valid);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            t++;
        end
        out_ready = 1'b1;
        if (expq.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
        end
    endtask

    task automatic rand_blk(output int x[8], input bit full);
        for (int i = 0; i < 8; i++) begin
            if (full) x[i] = int'($urandom_range(0, 524287)) - 262144;
            else      x[i] = int'($urandom_range(0, 600)) - 300;
        end
    endtask

    // Scoreboard monitor: a handshake completes on the next edge.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && en && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_output: got %h expected none", outv);
            end else begin
                e = expq.pop_front();
                for (int n = 0; n < 8; n++) begin
                    check($sformatf("sb_x%0d", n), longint'($signed(out_x[n])),
                          longint'($signed(e[8*n +: 8])));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   x[8];
        int   x2[8];
        int   n;
        int   w;
        real  pi;
        real  a;
        real  v;
        logic [63:0] snap;

        pi = 3.14159265358979;
        for (int k = 0; k < 8; k++) begin
            for (int m = 0; m < 8; m++) begin
                a = (k == 0) ? $sqrt(0.125) : 0.5;
                v = 2048.0 * a * $cos(real'((2 * m + 1) * k) * pi / 16.0);
                rom[k][m] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            end
        end

        rst = 1'b1; en = 1'b1; cs = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_z[i] = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", outv, 0);

        // DC recovery with latency
        x = '{200, 0, 0, 0, 0, 0, 0, 0};
        send(x, w);
        wait_valid(n);
        check("dc_latency", n, 9);
        check("dc_vals", outv, {8{8'd71}});
        drain();

        // AC1 antisymmetry
        x = '{0, 200, 0, 0, 0, 0, 0, 0};
        send(x, w);
        wait_valid(n);
        check("ac1_x0", $signed(out_x[0]), 98);
        check("ac1_x7", $signed(out_x[7]), -98);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ac1_sym%0d", i), $signed(out_x[i]), -$signed(out_x[7-i]));
        end
        drain();

        // Saturation both ways
        x = '{1000, 0, 0, 0, 0, 0, 0, 0};
        send(x, w);
        wait_valid(n);
        check("sat_pos", outv, {8{8'h7f}});
        drain();
        x = '{-1000, 0, 0, 0, 0, 0, 0, 0};
        send(x, w);
        wait_valid(n);
        check("sat_neg", outv, {8{8'h80}});
        drain();

        // Backpressure with a second block waiting
        out_ready = 1'b0;
        x = '{200, 0, 0, 0, 0, 0, 0, 0};
        send(x, w);
        wait_valid(n);
        snap = outv;
        x2 = '{0, 200, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) in_z[i] = 19'(x2[i]);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_stable", outv, snap);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", in_ready, 1);
        check("bp_release_valid", out_valid, 0);
        send(x2, w);
        check("bp_accept_next", w, 1);
        check("bp_busy", in_ready, 0);
        wait_valid(n);
        drain();

        // cs gating
        cs = 1'b0;
        in_valid = 1'b1;
        repeat (4) tick();
        check("cs_gate_ready", in_ready, 1);
        check("cs_gate_valid", out_valid, 0);
        in_valid = 1'b0;
        cs = 1'b1;

        // en stall during ACCUM, then en low in HOLD
        rand_blk(x, 1'b0);
        send(x, w);
        tick(); tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        wait_valid(n);
        check("stall_latency", n + 5, 12);
        en = 1'b0;
        repeat (2) tick();
        check("en_hold_valid", out_valid, 1);
        en = 1'b1;
        drain();

        // Reset mid-block at k=4
        rand_blk(x, 1'b0);
        x[0] = 500;
        send(x, w);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(expq.pop_back());
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_x", outv, 0);
        x = '{200, 0, 0, 0, 0, 0, 0, 0};
        send(x, w);
        wait_valid(n);
        check("mrst_dc_vals", outv, {8{8'd71}});
        drain();

        // Randomized blocks with random backpressure
        for (int b = 0; b < 20; b++) begin
            rand_blk(x, ($urandom_range(0, 3) == 0));
            send(x, w);
            drain();
        end

        repeat (3) tick();
        check("sb_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
